fwd_hazard_unit: RTL and testbench

Parametrised successor of the core's register/CSR forwarding logic. Adds a pending-write scoreboard for long-latency operations (loads, multiply/divide), so the EX stage can take operands from any of NFWD forwarding stages, from the long-latency writeback bus, or from the register file. It raises a stall when an operand is not yet available. Sits between the ID/EX pipeline register and the EX operand muxes.

---
 rtl/fwd_pkg.sv | 14 +
 rtl/fwd_scoreboard.sv | 55 +++++
 rtl/fwd_hazard_unit.sv | 126 ++++++++++++
 tb/tb_fwd_hazard_unit.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
// Shared select encodings and width helper for the forwarding/hazard unit.
package fwd_pkg;

  localparam int SEL_RF = 0;

  function automatic int clogw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int sel_lwb(input int nfwd);
    return nfwd + 1;
  endfunction

endpackage

// File: rtl/fwd_scoreboard.sv
// Pending-write scoreboard for long-latency results.
module fwd_scoreboard #(
  parameter int NREG   = 32,
  parameter int MAXOUT = 4,
  parameter int CW     = 3
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            set_i,
  input  logic [4:0]      set_rd_i,
  input  logic            clr_i,
  input  logic [4:0]      clr_rd_i,
  output logic [NREG-1:0] pend_o,
  output logic [CW-1:0]   cnt_o,
  output logic            full_o,
  output logic            hit_o
);

  logic [NREG-1:0] pend_q, pend_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            do_set;

  assign do_set = set_i && (set_rd_i != 5'd0);
  assign hit_o  = clr_i && pend_q[clr_rd_i];
  assign full_o = (cnt_q == CW'(MAXOUT));
  assign pend_o = pend_q;
  assign cnt_o  = cnt_q;

  // clear first so a same-register set overrides it
  always_comb begin
    pend_d = pend_q;
    if (hit_o) pend_d[clr_rd_i] = 1'b0;
    if (do_set) pend_d[set_rd_i] = 1'b1;
  end

  always_comb begin
    cnt_d = cnt_q;
    unique case ({do_set, hit_o})
      2'b10: if (!full_o) cnt_d = cnt_q + CW'(1);
      2'b01: if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand/CSR forwarding select and stall generation for EX.
// Optional stall counter port stall_cnt_o when FWD_PERF_EN is defined.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int NREG   = 32,
  parameter int NRS    = 2,
  parameter int NFWD   = 2,
  parameter int MAXOUT = 4,
  parameter int CSR_AW = 12,
  localparam int SELW  = clogw(NFWD + 2),
  localparam int CW    = clogw(MAXOUT + 1)
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [NRS*5-1:0]       rs_i,
  input  logic [NFWD*5-1:0]      fwd_rd_i,
  input  logic [NFWD-1:0]        fwd_wen_i,
  input  logic [NFWD-1:0]        fwd_ready_i,
  input  logic                   issue_i,
  input  logic                   issue_long_i,
  input  logic [4:0]             issue_rd_i,
  input  logic                   lwb_valid_i,
  input  logic [4:0]             lwb_rd_i,
  output logic [NRS*SELW-1:0]    fwd_sel_o,
  output logic                   stall_o,
  output logic [CW-1:0]          pend_cnt_o,
  input  logic [CSR_AW-1:0]      csr_addr_ex_i,
  input  logic [NFWD*CSR_AW-1:0] csr_addr_i,
  input  logic [NFWD-1:0]        csr_wen_i,
  output logic [SELW-1:0]        csr_sel_o
`ifdef FWD_PERF_EN
  ,
  output logic [31:0]            stall_cnt_o
`endif
);

  localparam logic [SELW-1:0] SelRf  = SELW'(SEL_RF);
  localparam logic [SELW-1:0] SelLwb = SELW'(sel_lwb(NFWD));

  logic [NREG-1:0] pend;
  logic            full;
  logic            clr_hit;
  logic            opnd_stall;
  logic            waw_stall;
  logic            full_stall;
  logic            sb_set;

  always_comb begin
    logic [4:0]      rs;
    logic [SELW-1:0] sel;
    logic            hit;
    logic            st;
    fwd_sel_o  = '0;
    opnd_stall = 1'b0;
    for (int k = 0; k < NRS; k++) begin
      rs  = rs_i[5*k +: 5];
      sel = SelRf;
      hit = 1'b0;
      st  = 1'b0;
      // walk far-to-near so the nearest stage wins
      for (int j = NFWD - 1; j >= 0; j--) begin
        if (fwd_wen_i[j] && (fwd_rd_i[5*j +: 5] == rs)) begin
          hit = 1'b1;
          sel = SELW'(j + 1);
          st  = !fwd_ready_i[j];
        end
      end
      if (!hit && pend[rs]) begin
        if (lwb_valid_i && (lwb_rd_i == rs)) sel = SelLwb;
        else st = 1'b1;
      end
      if (rs == 5'd0) begin
        sel = SelRf;
        st  = 1'b0;
      end
      fwd_sel_o[SELW*k +: SELW] = sel;
      opnd_stall = opnd_stall | st;
    end
  end

  assign waw_stall = issue_long_i && pend[issue_rd_i] &&
                     !(lwb_valid_i && (lwb_rd_i == issue_rd_i));
  assign full_stall = issue_long_i && full && !clr_hit;
  assign stall_o = opnd_stall | waw_stall | full_stall;
  assign sb_set = issue_i && issue_long_i && !stall_o;

  fwd_scoreboard #(
    .NREG  (NREG),
    .MAXOUT(MAXOUT),
    .CW    (CW)
  ) u_sb (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .set_i   (sb_set),
    .set_rd_i(issue_rd_i),
    .clr_i   (lwb_valid_i),
    .clr_rd_i(lwb_rd_i),
    .pend_o  (pend),
    .cnt_o   (pend_cnt_o),
    .full_o  (full),
    .hit_o   (clr_hit)
  );

  always_comb begin
    csr_sel_o = SelRf;
    for (int j = NFWD - 1; j >= 0; j--) begin
      if (csr_wen_i[j] &&
          (csr_addr_i[CSR_AW*j +: CSR_AW] == csr_addr_ex_i))
        csr_sel_o = SELW'(j + 1);
    end
  end

`ifdef FWD_PERF_EN
  logic [31:0] perf_q, perf_d;

  assign perf_d = stall_o ? perf_q + 32'd1 : perf_q;
  assign stall_cnt_o = perf_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) perf_q <= '0;
    else perf_q <= perf_d;
  end
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed-vector scoreboard bench for fwd_hazard_unit.
module tb_fwd_hazard_unit;

  logic        clk = 1'b0;
  logic        reset_i;
  logic [9:0]  rs_i;
  logic [9:0]  fwd_rd_i;
  logic [1:0]  fwd_wen_i;
  logic [1:0]  fwd_ready_i;
  logic        issue_i;
  logic        issue_long_i;
  logic [4:0]  issue_rd_i;
  logic        lwb_valid_i;
  logic [4:0]  lwb_rd_i;
  logic [3:0]  fwd_sel_o;
  logic        stall_o;
  logic [2:0]  pend_cnt_o;
  logic [11:0] csr_addr_ex_i;
  logic [23:0] csr_addr_i;
  logic [1:0]  csr_wen_i;
  logic [1:0]  csr_sel_o;
`ifdef FWD_PERF_EN
  logic [31:0] stall_cnt_o;
`endif

  always #5 clk = ~clk;

  fwd_hazard_unit dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .rs_i         (rs_i),
    .fwd_rd_i     (fwd_rd_i),
    .fwd_wen_i    (fwd_wen_i),
    .fwd_ready_i  (fwd_ready_i),
    .issue_i      (issue_i),
    .issue_long_i (issue_long_i),
    .issue_rd_i   (issue_rd_i),
    .lwb_valid_i  (lwb_valid_i),
    .lwb_rd_i     (lwb_rd_i),
    .fwd_sel_o    (fwd_sel_o),
    .stall_o      (stall_o),
    .pend_cnt_o   (pend_cnt_o),
    .csr_addr_ex_i(csr_addr_ex_i),
    .csr_addr_i   (csr_addr_i),
    .csr_wen_i    (csr_wen_i),
    .csr_sel_o    (csr_sel_o)
`ifdef FWD_PERF_EN
    ,
    .stall_cnt_o  (stall_cnt_o)
`endif
  );

  typedef struct {
    string      name;
    logic [3:0] sel;
    logic       stall;
    logic [2:0] cnt;
    logic [1:0] csel;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_vec++;
      if (fwd_sel_o !== e.sel || stall_o !== e.stall ||
          pend_cnt_o !== e.cnt || csr_sel_o !== e.csel) begin
        n_err++;
        $display("FAIL %s: got sel=%h stall=%b cnt=%0d csel=%0d, want sel=%h stall=%b cnt=%0d csel=%0d",
                 e.name, fwd_sel_o, stall_o, pend_cnt_o, csr_sel_o,
                 e.sel, e.stall, e.cnt, e.csel);
      end
    end
  end

  task automatic idle();
    reset_i       = 1'b0;
    rs_i          = '0;
    fwd_rd_i      = '0;
    fwd_wen_i     = '0;
    fwd_ready_i   = 2'b11;
    issue_i       = 1'b0;
    issue_long_i  = 1'b0;
    issue_rd_i    = '0;
    lwb_valid_i   = 1'b0;
    lwb_rd_i      = '0;
    csr_addr_ex_i = '0;
    csr_addr_i    = '0;
    csr_wen_i     = '0;
  endtask

  task automatic apply(input string nm, input logic [3:0] sel,
                       input logic st, input logic [2:0] cnt,
                       input logic [1:0] csel);
    exp_t e;
    e.name = nm; e.sel = sel; e.stall = st; e.cnt = cnt; e.csel = csel;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic long_issue(input logic [4:0] rd);
    idle();
    issue_i = 1'b1;
    issue_long_i = 1'b1;
    issue_rd_i = rd;
  endtask

  initial begin
    idle();
    reset_i = 1'b1;
    @(posedge clk);
    #1;
    reset_i = 1'b1;
    apply("reset", 4'h0, 1'b0, 3'd0, 2'd0);

    idle();
    rs_i = {5'd5, 5'd3}; fwd_rd_i = {5'd5, 5'd3}; fwd_wen_i = 2'b11;
    apply("fwd_both", 4'b1001, 1'b0, 3'd0, 2'd0);
    fwd_rd_i = {5'd3, 5'd3};
    apply("fwd_nearest", 4'b0001, 1'b0, 3'd0, 2'd0);

    idle();
    rs_i = {5'd0, 5'd7}; fwd_rd_i = {5'd0, 5'd7};
    fwd_wen_i = 2'b01; fwd_ready_i = 2'b10;
    apply("load_use", 4'b0001, 1'b1, 3'd0, 2'd0);
    fwd_ready_i = 2'b11;
    apply("load_ready", 4'b0001, 1'b0, 3'd0, 2'd0);

    long_issue(5'd9);
    apply("issue_x9", 4'h0, 1'b0, 3'd0, 2'd0);
    idle(); rs_i = {5'd0, 5'd9};
    apply("read_pend", 4'h0, 1'b1, 3'd1, 2'd0);
    lwb_valid_i = 1'b1; lwb_rd_i = 5'd9;
    apply("lwb_bypass", 4'b0011, 1'b0, 3'd1, 2'd0);
    idle(); rs_i = {5'd0, 5'd9};
    apply("after_clr", 4'h0, 1'b0, 3'd0, 2'd0);

    for (int i = 1; i <= 4; i++) begin
      long_issue(5'(i));
      apply("fill", 4'h0, 1'b0, 3'(i - 1), 2'd0);
    end
    long_issue(5'd5);
    apply("full_stall", 4'h0, 1'b1, 3'd4, 2'd0);
    lwb_valid_i = 1'b1; lwb_rd_i = 5'd2;
    apply("full_lwb", 4'h0, 1'b0, 3'd4, 2'd0);
    idle(); rs_i = {5'd5, 5'd2};
    apply("cnt_held", 4'h0, 1'b1, 3'd4, 2'd0);

    idle(); lwb_valid_i = 1'b1; lwb_rd_i = 5'd1;
    apply("clr_x1", 4'h0, 1'b0, 3'd4, 2'd0);
    lwb_rd_i = 5'd12;
    apply("clr_nonpend", 4'h0, 1'b0, 3'd3, 2'd0);
    long_issue(5'd3);
    apply("waw", 4'h0, 1'b1, 3'd3, 2'd0);
    lwb_valid_i = 1'b1; lwb_rd_i = 5'd3;
    apply("waw_clr", 4'h0, 1'b0, 3'd3, 2'd0);
    idle(); rs_i = {5'd0, 5'd3};
    apply("set_wins", 4'h0, 1'b1, 3'd3, 2'd0);

    long_issue(5'd7); reset_i = 1'b1;
    apply("reset_busy", 4'h0, 1'b0, 3'd3, 2'd0);
    idle(); rs_i = {5'd7, 5'd3};
    apply("post_reset", 4'h0, 1'b0, 3'd0, 2'd0);
    long_issue(5'd0);
    apply("issue_x0", 4'h0, 1'b0, 3'd0, 2'd0);
    idle(); rs_i = {5'd0, 5'd0}; fwd_wen_i = 2'b11; fwd_ready_i = 2'b00;
    apply("x0_cnt", 4'h0, 1'b0, 3'd0, 2'd0);

    idle(); csr_addr_ex_i = 12'h300;
    csr_addr_i = {12'h300, 12'h300}; csr_wen_i = 2'b11;
    apply("csr_near", 4'h0, 1'b0, 3'd0, 2'd1);
    csr_wen_i = 2'b10;
    apply("csr_far", 4'h0, 1'b0, 3'd0, 2'd2);
    csr_addr_i = {12'h300, 12'h301}; csr_wen_i = 2'b11;
    apply("csr_addr", 4'h0, 1'b0, 3'd0, 2'd2);

`ifdef FWD_PERF_EN
    idle(); rs_i = {5'd0, 5'd7}; fwd_rd_i = {5'd0, 5'd7};
    fwd_wen_i = 2'b01; fwd_ready_i = 2'b10;
    for (int i = 0; i < 3; i++)
      apply("perf_stall", 4'b0001, 1'b1, 3'd0, 2'd0);
    idle();
    apply("perf_idle", 4'h0, 1'b0, 3'd0, 2'd0);
    n_vec++;
    if (stall_cnt_o !== 32'd3) begin
      n_err++;
      $display("FAIL stall_cnt: got %0d want 3", stall_cnt_o);
    end
`endif

    idle();
    for (int t = 0; t < 10 && exp_q.size() != 0; t++) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
